// File: rtl/fma_accumulator_pkg.sv
// Shared definitions for the FMA accumulator and its upstream operand sequencer.
// Optional feature macro: FMA_ACC_SATURATE_EN (clamp the accumulator on overflow).
package fma_accumulator_pkg;

  localparam int IN_W    = 64;
  localparam int GUARD_W = 8;
  localparam int ACC_W   = IN_W + GUARD_W;
  localparam int CNT_W   = 8;
  localparam int BLK_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fma_accumulator_if.sv
// Request, input-stream and result handshake bundle of the FMA accumulator.
interface fma_accumulator_if #(
  parameter int IN_W  = 64,
  parameter int CNT_W = 8,
  parameter int ACC_W = 72
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  // Producer/consumer side: issues runs, streams FMA results, takes the sum
  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  // Accumulator side
  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

endinterface

// File: rtl/fma_accumulator_csel_adder.sv
// Combinational carry-select adder for the accumulator, built from full-adder cells.
// Each BLK_W block computes both carry-in hypotheses with ripple chains and the
// incoming block carry selects one, so the critical path is one ripple block
// plus a mux per block.

// Gate-level full-adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module csel_adder_acc #(
  parameter int ACC_W = 72,
  parameter int BLK_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  localparam int NBLK = ACC_W / BLK_W;

  logic [NBLK:0] blk_c;

  assign blk_c[0] = 1'b0;

  // One block: speculative sums for carry-in 0 and 1, then select by real carry
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK_W:0]   c0;
    logic [BLK_W:0]   c1;
    logic [BLK_W-1:0] s0;
    logic [BLK_W-1:0] s1;

    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;

    for (genvar i = 0; i < BLK_W; i++) begin : g_bit
      fa_cell u_fa0 (
        .a  (a[g*BLK_W + i]),
        .b  (b[g*BLK_W + i]),
        .ci (c0[i]),
        .s  (s0[i]),
        .co (c0[i+1])
      );
      fa_cell u_fa1 (
        .a  (a[g*BLK_W + i]),
        .b  (b[g*BLK_W + i]),
        .ci (c1[i]),
        .s  (s1[i]),
        .co (c1[i+1])
      );
    end

    assign sum[g*BLK_W +: BLK_W] = blk_c[g] ? s1 : s0;
    assign blk_c[g+1]            = blk_c[g] ? c1[BLK_W] : c0[BLK_W];
  end

  assign cout = blk_c[NBLK];

endmodule

// File: rtl/fma_accumulator.sv
// Sums a programmed number of FMA results into a wide accumulator and hands the
// total back through a valid/ready port with a sticky overflow flag.
// Optional feature macro: FMA_ACC_SATURATE_EN (clamp to all-ones on overflow
// instead of wrapping).
module fma_accumulator #(
  parameter int IN_W    = fma_accumulator_pkg::IN_W,
  parameter int GUARD_W = fma_accumulator_pkg::GUARD_W,
  parameter int CNT_W   = fma_accumulator_pkg::CNT_W,
  parameter int BLK_W   = fma_accumulator_pkg::BLK_W,
  localparam int ACC_W  = IN_W + GUARD_W
) (
  input  logic              clk,
  input  logic              rst,
  fma_accumulator_if.slave  bus
);

  import fma_accumulator_pkg::*;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic             beat;

  assign add_b = ACC_W'(bus.in_data);
  assign beat  = (state_q == ACCUM) && bus.in_valid;

  csel_adder_acc #(
    .ACC_W (ACC_W),
    .BLK_W (BLK_W)
  ) u_adder (
    .a    (acc_q),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, accumulator, beat counter and overflow flag
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = bus.len;
          state_d = (bus.len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (beat) begin
`ifdef FMA_ACC_SATURATE_EN
          acc_d = add_cout ? '1 : add_sum;
`else
          acc_d = add_sum;
`endif
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register all state; reset aborts any run immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_fma_accumulator.sv
// Directed self-checking bench for fma_accumulator: a default-width instance and
// a GUARD_W=0 instance for the 64-bit overflow case.
module tb_fma_accumulator;

  logic clk;
  logic rst;

  int checks;
  int failures;

  fma_accumulator_if #(.IN_W(64), .CNT_W(8), .ACC_W(72)) bus ();
  fma_accumulator_if #(.IN_W(64), .CNT_W(8), .ACC_W(64)) bus_o ();

  fma_accumulator #(.IN_W(64), .GUARD_W(8), .CNT_W(8), .BLK_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fma_accumulator #(.IN_W(64), .GUARD_W(0), .CNT_W(8), .BLK_W(8)) dut_o (
    .clk (clk),
    .rst (rst),
    .bus (bus_o)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.len = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    bus_o.start = 0; bus_o.len = 0; bus_o.in_valid = 0; bus_o.in_data = 0; bus_o.out_ready = 0;
    #2;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_ovf} !== 4'b0000 || bus.out_data !== 72'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b busy=%b ovf=%b data=%0d, want all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_ovf, bus.out_data);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    logic [63:0] beats [3];
    beats[0] = 64'd8161; beats[1] = 64'd386; beats[2] = 64'd1379;
    bus.start = 1; bus.len = 8'd3;
    tick();
    bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = beats[i];
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL nominal_accum beat%0d: got rdy=%b busy=%b vld=%b, want 1 1 0",
                 i, bus.in_ready, bus.busy, bus.out_valid);
      end
      tick();
    end
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 72'd9926 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nominal_done: got vld=%b data=%0d ovf=%b rdy=%b, want 1 9926 0 0",
               bus.out_valid, bus.out_data, bus.out_ovf, bus.in_ready);
    end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 72'd9926) begin
      failures++;
      $display("[TB] FAIL nominal_idle: got vld=%b busy=%b data=%0d, want 0 0 9926",
               bus.out_valid, bus.busy, bus.out_data);
    end
  endtask

  task automatic test_stalls();
    int handshakes;
    bus.start = 1; bus.len = 8'd2;
    tick();
    bus.start = 0;
    bus.in_valid = 1; bus.in_data = 64'd5;
    tick();
    bus.in_valid = 0; bus.in_data = 64'd999;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 72'd5) begin
        failures++;
        $display("[TB] FAIL stall_hold cyc%0d: got rdy=%b vld=%b data=%0d, want 1 0 5",
                 i, bus.in_ready, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.in_valid = 1; bus.in_data = 64'd7;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 72'd12 || bus.out_ovf !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold cyc%0d: got vld=%b data=%0d ovf=%b, want 1 12 0",
                 i, bus.out_valid, bus.out_data, bus.out_ovf);
      end
      tick();
    end
    handshakes = 0;
    bus.out_ready = 1;
    if (bus.out_valid) handshakes++;
    tick();
    bus.out_ready = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || handshakes != 1) begin
      failures++;
      $display("[TB] FAIL stall_handshake: got vld=%b handshakes=%0d, want 0 1", bus.out_valid, handshakes);
    end
  endtask

  task automatic test_zero_len();
    bus.in_valid = 1; bus.in_data = 64'd77;
    bus.start = 1; bus.len = 8'd0;
    tick();
    bus.start = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 72'd0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_len_done: got vld=%b data=%0d ovf=%b rdy=%b, want 1 0 0 0",
               bus.out_valid, bus.out_data, bus.out_ovf, bus.in_ready);
    end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 72'd0) begin
      failures++;
      $display("[TB] FAIL zero_len_idle: got rdy=%b vld=%b data=%0d, want 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    bus.in_valid = 0;
  endtask

  task automatic test_overflow();
    logic [63:0] exp_o;
`ifdef FMA_ACC_SATURATE_EN
    exp_o = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_o = 64'hFFFF_FFFF_FFFF_FFFE;
`endif
    bus.start = 1; bus.len = 8'd2;
    bus_o.start = 1; bus_o.len = 8'd2;
    tick();
    bus.start = 0; bus_o.start = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      bus_o.in_valid = 1; bus_o.in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
    end
    bus.in_valid = 0; bus_o.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 72'h1_FFFF_FFFF_FFFF_FFFE || bus.out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL guard_no_ovf: got vld=%b data=%h ovf=%b, want 1 1fffffffffffffffe 0",
               bus.out_valid, bus.out_data, bus.out_ovf);
    end
    checks++;
    if (bus_o.out_valid !== 1'b1 || bus_o.out_data !== exp_o || bus_o.out_ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf64: got vld=%b data=%h ovf=%b, want 1 %h 1",
               bus_o.out_valid, bus_o.out_data, bus_o.out_ovf, exp_o);
    end
    bus.out_ready = 1; bus_o.out_ready = 1;
    tick();
    bus.out_ready = 0; bus_o.out_ready = 0;
    checks++;
    if (bus_o.out_ovf !== 1'b1 || bus_o.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_sticky_idle: got ovf=%b vld=%b, want 1 0", bus_o.out_ovf, bus_o.out_valid);
    end
    bus_o.start = 1; bus_o.len = 8'd1;
    tick();
    bus_o.start = 0;
    bus_o.in_valid = 1; bus_o.in_data = 64'd1;
    tick();
    bus_o.in_valid = 0;
    checks++;
    if (bus_o.out_valid !== 1'b1 || bus_o.out_data !== 64'd1 || bus_o.out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_cleared_by_start: got vld=%b data=%0d ovf=%b, want 1 1 0",
               bus_o.out_valid, bus_o.out_data, bus_o.out_ovf);
    end
    bus_o.out_ready = 1;
    tick();
    bus_o.out_ready = 0;
  endtask

  task automatic test_midrun_reset();
    bus.start = 1; bus.len = 8'd4;
    tick();
    bus.start = 0;
    bus.in_valid = 1; bus.in_data = 64'd100;
    tick();
    bus.in_data = 64'd200;
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_data !== 72'd300 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_partial: got data=%0d vld=%b, want 300 0", bus.out_data, bus.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_ovf} !== 4'b0000 || bus.out_data !== 72'd0) begin
      failures++;
      $display("[TB] FAIL midrun_async_reset: got rdy=%b vld=%b busy=%b ovf=%b data=%0d, want all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_ovf, bus.out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got vld=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_ignored_start();
    bus.start = 1; bus.len = 8'd1;
    tick();
    bus.len = 8'd5;
    tick();
    bus.start = 0;
    bus.in_valid = 1; bus.in_data = 64'd42;
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 72'd42) begin
      failures++;
      $display("[TB] FAIL ignored_start_result: got vld=%b data=%0d, want 1 42", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_not_queued: got busy=%b vld=%b rdy=%b, want 0 0 0",
               bus.busy, bus.out_valid, bus.in_ready);
    end
  endtask

  // Scenario sequence
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_stalls();
    test_zero_len();
    test_overflow();
    test_midrun_reset();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fma_accumulator.md
Name: fma_accumulator

Overview:
- Downstream stage of the 32x32+64 FMA datapath: consumes the FMA's 64-bit result stream and sums a programmed number of results into a wide accumulator.
- Returns the final sum through a valid/ready output, plus a sticky overflow flag.
- Implements dot-product / MAC reduction over FMA outputs; the adder core is built as a gate-level carry-select adder.

Parameters:
- IN_W, 64, width of each FMA result word.
- GUARD_W, 8, guard bits above IN_W; ACC_W = IN_W + GUARD_W.
- CNT_W, 8, width of the beat-count input; max run length 2^CNT_W - 1.
- BLK_W, 8, carry-select block width inside the adder sub-module; ACC_W must be a multiple of BLK_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- len  in  CNT_W  number of FMA results to sum; captured with start.
- in_valid  in  1  FMA result present on in_data.
- in_data  in  IN_W  FMA result, unsigned.
- in_ready  out  1  accumulator accepts in_data this cycle.
- out_valid  out  1  final sum available.
- out_ready  in  1  consumer takes out_data.
- out_data  out  ACC_W  accumulated sum.
- out_ovf  out  1  sticky overflow for the current run.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0, cnt=0; in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: clear acc and ovf, load cnt=len, go to ACCUM.
  - start=1 and len==0: clear acc and ovf, go directly to DONE; result is 0.
- ACCUM:
  - in_ready=1 (combinational from state only, never from in_valid).
  - Beat accepted when in_valid && in_ready: acc <= acc + zero-extended in_data on that edge, and cnt decrements.
  - When cnt==1 and a beat is accepted: go to DONE.
  - Cycles with in_valid=0 are stalls: acc and cnt hold.
- DONE:
  - out_valid=1; out_data=acc; out_ovf valid.
  - Held stable until out_ready=1; the handshake edge returns the FSM to IDLE with out_valid=0.
  - out_data and out_ovf retain their last values in IDLE.
- Latency: out_valid rises on the first edge after the last beat is accepted (1 cycle). Back-to-back runs need 1 IDLE cycle between DONE and the next start.
- start outside IDLE is ignored; it is not queued.
- Arithmetic and overflow:
  - Unsigned, ACC_W-bit sum.
  - Carry-out of the MSB sets out_ovf, which stays set until the next start.
  - Without saturation the sum wraps modulo 2^ACC_W.
- Reset asserted mid-run aborts immediately to the reset values. A partial sum is never emitted.
- in_data is not sampled outside ACCUM; an upstream holding in_valid high is simply back-pressured.

Optional Feature:
- Macro: FMA_ACC_SATURATE_EN.
- Defined:
  - On overflow, acc clamps to all-ones (2^ACC_W - 1) and stays clamped for the rest of the run.
  - out_ovf is still set.
- Undefined:
  - Wrap-around behaviour as above.
  - No clamp logic is synthesised.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Default width constants IN_W, GUARD_W, ACC_W.
  - These are reused by the upstream operand sequencer.
- One sub-module, csel_adder_acc:
  - Purely combinational ACC_W-bit carry-select adder in BLK_W blocks.
  - Inputs: a, b; outputs: sum, cout.
  - Built from the team's gate-level full-adder cells.
  - The FSM, counter and registers stay in fma_accumulator.

Test Plan:
- Nominal run: reset then release; start with len=3; feed 8161, 386, 1379 on consecutive cycles -> out_valid 1 cycle after third beat, out_data=9926, out_ovf=0; out_ready=1 -> IDLE next cycle.
- Stalls and back-pressure: len=2; in_valid low for 3 cycles between beats 5 and 7; out_ready held low 4 cycles -> out_data=12 held stable with out_valid=1 throughout; single handshake.
- Zero length: start with len=0 -> DONE next cycle, out_data=0, out_ovf=0; in_ready never asserted.
- Overflow: len=2, both beats 2^64-1, GUARD_W=0 (ACC_W=64):
  - Without macro -> out_data=2^64-2, out_ovf=1.
  - With FMA_ACC_SATURATE_EN -> out_data=2^64-1, out_ovf=1.
- Mid-run reset and ignored start: len=4, assert rst after 2 beats -> all outputs zero asynchronously, no out_valid. Then pulse start during ACCUM of a new len=1 run -> ignored, single result equals the one beat.
